// File: rtl/elevator_pkg.sv
// Shared types and constants for the hall call scheduler.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package elevator_pkg;

   // Width of the current_floor bus (floors 1..15 representable).
   localparam int FLOOR_W = 4;

   // Scheduler state encoding.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MOVE  = 2'd1,
      DOORS = 2'd2,
      HALT  = 2'd3
   } state_t;

   // Codes driven on the direction output.
   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   // Direction code for a car that is actually travelling.
   function automatic logic [1:0] dir_code(input logic up);
      return up ? DIR_UP : DIR_DOWN;
   endfunction

endpackage

// File: rtl/door_timer.sv
// Load / reload / count-down timer with a done flag, reused for travel and door timing.
// Latency: load takes effect on the next edge; done is decoded from the count register.
// Backpressure: none; dec is ignored once the count has reached zero.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset (count -> 0)
//   clear      : force the count to zero (higher priority than load)
//   load       : load RELOAD (higher priority than dec)
//   dec        : decrement by one while non-zero
//   done       : count is zero
module door_timer
   import elevator_pkg::*;
#(
   parameter int WIDTH  = 2,
   parameter int RELOAD = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic load,
   input  logic dec,
   output logic done
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (load) begin
         count <= WIDTH'(RELOAD);
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/hall_call_scheduler.sv
// Latches hall/car calls and runs the car through SCAN travel and door phases.
// Latency: calls visible in pending the edge they are sampled; IDLE acts one edge later.
// Backpressure: none; stop freezes motion and doors while calls keep latching.
//
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   hall_call, car_call : per-floor call requests, bit i = floor i+1, level or pulse
//   hold_door           : door-open button, restarts the door timer
//   stop                : freeze request, forces HALT while high
//   current_floor       : floor the car is at, 1..NUM_FLOORS
//   direction           : 00 stopped, 01 up, 10 down (non-zero only while moving)
//   door_open           : door is open
//   arrive              : one-cycle pulse on each floor arrival
//   pending             : latched calls not yet served
module hall_call_scheduler
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS    = 9,
   parameter int TRAVEL_CYCLES = 2,
   parameter int DOOR_CYCLES   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] hall_call,
   input  logic [NUM_FLOORS-1:0] car_call,
   input  logic                  hold_door,
   input  logic                  stop,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic [1:0]            direction,
   output logic                  door_open,
   output logic                  arrive,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int TRAV_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

   // Thermometer masks: floors strictly above / below f, and the one-hot bit of f.
   function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      for (int i = 0; i < NUM_FLOORS; i++) m[i] = ((i + 1) > int'(f));
      return m;
   endfunction

   function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      for (int i = 0; i < NUM_FLOORS; i++) m[i] = ((i + 1) < int'(f));
      return m;
   endfunction

   function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      for (int i = 0; i < NUM_FLOORS; i++) m[i] = ((i + 1) == int'(f));
      return m;
   endfunction

   state_t                state, state_nxt;
   logic                  dir_up, dir_up_nxt;
   logic [FLOOR_W-1:0]    floor_nxt;
   logic                  arrive_nxt;
   logic [NUM_FLOORS-1:0] clear_bits;
   logic [NUM_FLOORS-1:0] pending_nxt;

   logic travel_load, travel_dec, travel_done;
   logic door_load, door_dec, door_done;
   logic timers_clr;

   // Request and position decode.
   logic [NUM_FLOORS-1:0] calls;
   logic [NUM_FLOORS-1:0] cur_bit;
   logic                  work_up, work_dn, here_pend;
   logic                  ahead, behind;
   logic                  at_top, at_bot, can_step;
   logic [FLOOR_W-1:0]    step_floor;
   logic [NUM_FLOORS-1:0] step_bit;
   logic                  step_pend, step_ahead;
   logic                  door_reload;

   assign calls     = hall_call | car_call;
   assign cur_bit   = floor_bit(current_floor);
   assign work_up   = |(pending & above_mask(current_floor));
   assign work_dn   = |(pending & below_mask(current_floor));
   assign here_pend = |(pending & cur_bit);
   assign ahead     = dir_up ? work_up : work_dn;
   assign behind    = dir_up ? work_dn : work_up;

   assign at_top    = (current_floor == FLOOR_W'(NUM_FLOORS));
   assign at_bot    = (current_floor == FLOOR_W'(1));
   assign can_step  = dir_up ? !at_top : !at_bot;

   // Floor the car reaches on the next step, and what is waiting there / beyond it.
   assign step_floor = dir_up ? (current_floor + FLOOR_W'(1)) : (current_floor - FLOOR_W'(1));
   assign step_bit   = floor_bit(step_floor);
   assign step_pend  = |(pending & step_bit);
   assign step_ahead = |(pending & (dir_up ? above_mask(step_floor) : below_mask(step_floor)));

   // A press for the landing the door is open at keeps the door open instead of latching.
   assign door_reload = hold_door || (|(calls & cur_bit));

   always_comb begin
      state_nxt   = state;
      dir_up_nxt  = dir_up;
      floor_nxt   = current_floor;
      arrive_nxt  = 1'b0;
      clear_bits  = '0;
      travel_load = 1'b0;
      travel_dec  = 1'b0;
      door_load   = 1'b0;
      door_dec    = 1'b0;
      timers_clr  = 1'b0;

      if (stop) begin
         state_nxt  = HALT;
         timers_clr = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (here_pend) begin
                  state_nxt  = DOORS;
                  door_load  = 1'b1;
                  clear_bits = cur_bit;
               end else if (ahead) begin
                  state_nxt   = MOVE;
                  travel_load = 1'b1;
               end else if (behind) begin
                  dir_up_nxt  = !dir_up;
                  state_nxt   = MOVE;
                  travel_load = 1'b1;
               end else if ((dir_up && at_top) || (!dir_up && at_bot)) begin
                  // Facing the end of the shaft: turn round so the next scan heads inward.
                  dir_up_nxt = !dir_up;
               end
            end

            MOVE: begin
               if (!travel_done) begin
                  travel_dec = 1'b1;
               end else if (!can_step) begin
                  state_nxt = IDLE;
               end else begin
                  floor_nxt  = step_floor;
                  arrive_nxt = 1'b1;
                  if (step_pend) begin
                     state_nxt  = DOORS;
                     door_load  = 1'b1;
                     clear_bits = step_bit;
                  end else if (step_ahead) begin
                     travel_load = 1'b1;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end

            DOORS: begin
               if (door_reload) begin
                  door_load = 1'b1;
               end else if (door_done) begin
                  state_nxt = IDLE;
               end else begin
                  door_dec = 1'b1;
               end
            end

            HALT: begin
               state_nxt = IDLE;
            end

            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      pending_nxt = pending | (calls & ~((state == DOORS) ? cur_bit : '0));
      pending_nxt = pending_nxt & ~clear_bits;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         dir_up        <= 1'b1;
         current_floor <= FLOOR_W'(1);
         direction     <= DIR_IDLE;
         door_open     <= 1'b0;
         arrive        <= 1'b0;
         pending       <= '0;
      end else begin
         state         <= state_nxt;
         dir_up        <= dir_up_nxt;
         current_floor <= floor_nxt;
         direction     <= (state_nxt == MOVE) ? dir_code(dir_up_nxt) : DIR_IDLE;
         door_open     <= (state_nxt == DOORS);
         arrive        <= arrive_nxt;
         pending       <= pending_nxt;
      end
   end

   door_timer #(
      .WIDTH  (TRAV_W),
      .RELOAD (TRAVEL_CYCLES - 1)
   ) u_travel_timer (
      .clk   (clk),
      .reset (reset),
      .clear (timers_clr),
      .load  (travel_load),
      .dec   (travel_dec),
      .done  (travel_done)
   );

   door_timer #(
      .WIDTH  (DOOR_W),
      .RELOAD (DOOR_CYCLES - 1)
   ) u_door_timer (
      .clk   (clk),
      .reset (reset),
      .clear (timers_clr),
      .load  (door_load),
      .dec   (door_dec),
      .done  (door_done)
   );

endmodule

// File: tb/tb_hall_call_scheduler.sv
// Directed bench for hall_call_scheduler with a timed scoreboard and an arrival scoreboard.
// Latency: checkpoints are keyed to absolute clock-edge numbers, sampled on the falling edge.
// Backpressure: n/a.
module tb_hall_call_scheduler;

   localparam int NF = 9;
   localparam logic [1:0] DI = 2'b00;
   localparam logic [1:0] DU = 2'b01;
   localparam logic [1:0] DD = 2'b10;

   logic          clk = 1'b0;
   logic          reset;
   logic [NF-1:0] hall_call;
   logic [NF-1:0] car_call;
   logic          hold_door;
   logic          stop;
   logic [3:0]    current_floor;
   logic [1:0]    direction;
   logic          door_open;
   logic          arrive;
   logic [NF-1:0] pending;

   hall_call_scheduler #(
      .NUM_FLOORS    (NF),
      .TRAVEL_CYCLES (2),
      .DOOR_CYCLES   (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .hall_call     (hall_call),
      .car_call      (car_call),
      .hold_door     (hold_door),
      .stop          (stop),
      .current_floor (current_floor),
      .direction     (direction),
      .door_open     (door_open),
      .arrive        (arrive),
      .pending       (pending)
   );

   always #5 clk = ~clk;

   // Number of rising edges seen so far; a checkpoint "at k" is the state after edge k.
   int edge_n = 0;
   always @(posedge clk) edge_n++;

   typedef struct {
      int            at;
      logic [3:0]    floor;
      logic [1:0]    dir;
      logic          door;
      logic [NF-1:0] pend;
      string         name;
   } exp_t;

   exp_t exp_q[$];
   int   arr_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Insert an expected snapshot, kept ordered by edge number.
   task automatic expect_at(input int at, input int fl, input logic [1:0] d,
                            input logic door, input logic [NF-1:0] p, input string name);
      exp_t e;
      int   pos;
      e.at    = at;
      e.floor = 4'(fl);
      e.dir   = d;
      e.door  = door;
      e.pend  = p;
      e.name  = name;
      pos = exp_q.size();
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].at > at) begin
            pos = i;
            break;
         end
      end
      exp_q.insert(pos, e);
   endtask

   task automatic goto_edge(input int k);
      while (edge_n < k - 1) @(negedge clk);
   endtask

   // Monitor: compares scheduled snapshots and every arrive pulse.
   exp_t m_e;
   int   m_fl;
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].at <= edge_n) begin
         m_e = exp_q.pop_front();
         vectors++;
         if (m_e.at != edge_n) begin
            miscompares++;
            $display("FAIL %s: checkpoint for edge %0d reached only at edge %0d", m_e.name, m_e.at, edge_n);
         end else if (current_floor !== m_e.floor || direction !== m_e.dir ||
                      door_open !== m_e.door || pending !== m_e.pend) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got floor=%0d dir=%b door=%b pend=%h, required floor=%0d dir=%b door=%b pend=%h",
                     m_e.name, edge_n, current_floor, direction, door_open, pending,
                     m_e.floor, m_e.dir, m_e.door, m_e.pend);
         end
      end
      if (arrive === 1'b1) begin
         vectors++;
         if (arr_q.size() == 0) begin
            miscompares++;
            $display("FAIL arrive @edge %0d: unexpected pulse at floor %0d, required none", edge_n, current_floor);
         end else begin
            m_fl = arr_q.pop_front();
            if (current_floor !== 4'(m_fl)) begin
               miscompares++;
               $display("FAIL arrive @edge %0d: got floor %0d, required floor %0d", edge_n, current_floor, m_fl);
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: bench did not complete, %0d checks still queued", exp_q.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with every input driven hard: reset must beat stop and the calls.
      reset     = 1'b1;
      stop      = 1'b1;
      hall_call = '1;
      car_call  = '1;
      hold_door = 1'b1;
      expect_at(2, 1, DI, 0, 9'h000, "reset_hold");
      expect_at(3, 1, DI, 0, 9'h000, "reset_hold");
      goto_edge(4);
      reset = 1'b0; stop = 1'b0; hall_call = '0; car_call = '0; hold_door = 1'b0;

      // Quiet idle for 20 cycles.
      for (int k = 4; k <= 23; k++) expect_at(k, 1, DI, 0, 9'h000, "idle_quiet");

      // Hall call for floor 3 from floor 1.
      expect_at(25, 1, DI, 0, 9'h004, "f3_latch");
      expect_at(26, 1, DU, 0, 9'h004, "f3_move");
      expect_at(27, 1, DU, 0, 9'h004, "f3_travel");
      expect_at(28, 2, DU, 0, 9'h004, "f3_floor2");
      expect_at(29, 2, DU, 0, 9'h004, "f3_travel2");
      expect_at(30, 3, DI, 1, 9'h000, "f3_doors");
      expect_at(31, 3, DI, 1, 9'h000, "f3_door_hi");
      expect_at(33, 3, DI, 1, 9'h000, "f3_door_last");
      expect_at(34, 3, DI, 0, 9'h000, "f3_door_closed");
      arr_q.push_back(2); arr_q.push_back(3);
      goto_edge(25); hall_call = 9'h004;
      goto_edge(26); hall_call = '0;

      // SCAN: go up to 7, floor 2 called while passing 5, then reverse down to 2.
      expect_at(36, 3, DI, 0, 9'h040, "scan_latch7");
      expect_at(37, 3, DU, 0, 9'h040, "scan_up");
      expect_at(39, 4, DU, 0, 9'h040, "scan_f4");
      expect_at(41, 5, DU, 0, 9'h042, "scan_f5_call2");
      expect_at(43, 6, DU, 0, 9'h042, "scan_f6");
      expect_at(45, 7, DI, 1, 9'h002, "scan_stop7");
      expect_at(48, 7, DI, 1, 9'h002, "scan_door7");
      expect_at(49, 7, DI, 0, 9'h002, "scan_close7");
      expect_at(50, 7, DD, 0, 9'h002, "scan_reverse");
      expect_at(52, 6, DD, 0, 9'h002, "scan_down6");
      expect_at(58, 3, DD, 0, 9'h002, "scan_down3");
      expect_at(60, 2, DI, 1, 9'h000, "scan_stop2");
      expect_at(63, 2, DI, 1, 9'h000, "scan_door2");
      expect_at(64, 2, DI, 0, 9'h000, "scan_close2");
      for (int f = 4; f <= 7; f++) arr_q.push_back(f);
      for (int f = 6; f >= 2; f--) arr_q.push_back(f);
      goto_edge(36); car_call = 9'h040;
      goto_edge(37); car_call = '0;
      goto_edge(41); car_call = 9'h002;
      goto_edge(42); car_call = '0;

      // Door at current floor, held 6 cycles, then re-pressed from the landing.
      expect_at(66, 2, DI, 0, 9'h002, "hold_latch");
      expect_at(67, 2, DI, 1, 9'h000, "hold_open_here");
      expect_at(73, 2, DI, 1, 9'h000, "hold_held");
      expect_at(75, 2, DI, 1, 9'h000, "hold_call_not_latched");
      expect_at(76, 2, DI, 1, 9'h000, "hold_after_call");
      expect_at(77, 2, DI, 1, 9'h000, "hold_reload_kept");
      expect_at(78, 2, DI, 1, 9'h000, "hold_last");
      expect_at(79, 2, DI, 0, 9'h000, "hold_closed");
      goto_edge(66); hall_call = 9'h002;
      goto_edge(67); hall_call = '0;
      goto_edge(68); hold_door = 1'b1;
      goto_edge(74); hold_door = 1'b0;
      goto_edge(75); hall_call = 9'h002;
      goto_edge(76); hall_call = '0;

      // Stop between floors 3 and 4, call 6 during HALT, resume.
      expect_at(81,  2, DI, 0, 9'h008, "halt_latch4");
      expect_at(82,  2, DU, 0, 9'h008, "halt_up");
      expect_at(84,  3, DU, 0, 9'h008, "halt_f3");
      expect_at(85,  3, DI, 0, 9'h008, "halt_enter");
      expect_at(87,  3, DI, 0, 9'h028, "halt_latch6");
      expect_at(90,  3, DI, 0, 9'h028, "halt_frozen");
      expect_at(91,  3, DI, 0, 9'h028, "halt_release");
      expect_at(92,  3, DU, 0, 9'h028, "halt_resume");
      expect_at(93,  3, DU, 0, 9'h028, "halt_progress_lost");
      expect_at(94,  4, DI, 1, 9'h020, "halt_stop4");
      expect_at(98,  4, DI, 0, 9'h020, "halt_close4");
      expect_at(99,  4, DU, 0, 9'h020, "halt_to6");
      expect_at(101, 5, DU, 0, 9'h020, "halt_f5");
      expect_at(103, 6, DI, 1, 9'h000, "halt_stop6");
      for (int f = 3; f <= 6; f++) arr_q.push_back(f);
      goto_edge(81); car_call = 9'h008;
      goto_edge(82); car_call = '0;
      goto_edge(85); stop = 1'b1;
      goto_edge(87); car_call = 9'h020;
      goto_edge(88); car_call = '0;
      goto_edge(91); stop = 1'b0;

      // Reset while the door is open at floor 4 with a call pending.
      expect_at(107, 6, DI, 0, 9'h000, "rst_idle6");
      expect_at(108, 6, DI, 0, 9'h008, "rst_latch4");
      expect_at(109, 6, DD, 0, 9'h008, "rst_down");
      expect_at(111, 5, DD, 0, 9'h008, "rst_f5");
      expect_at(113, 4, DI, 1, 9'h000, "rst_door4");
      expect_at(114, 4, DI, 1, 9'h100, "rst_pending9");
      expect_at(115, 1, DI, 0, 9'h000, "rst_mid_doors");
      expect_at(117, 1, DI, 0, 9'h000, "rst_after");
      arr_q.push_back(5); arr_q.push_back(4);
      goto_edge(108); car_call = 9'h008;
      goto_edge(109); car_call = '0;
      goto_edge(114); hall_call = 9'h100;
      goto_edge(115); hall_call = '0; reset = 1'b1;
      goto_edge(116); reset = 1'b0;

      // Top floor: travel to floor 9, stay in range, then go back down to 8.
      expect_at(118, 1, DI, 0, 9'h100, "top_latch9");
      expect_at(119, 1, DU, 0, 9'h100, "top_up");
      expect_at(121, 2, DU, 0, 9'h100, "top_f2");
      expect_at(127, 5, DU, 0, 9'h100, "top_f5");
      expect_at(133, 8, DU, 0, 9'h100, "top_f8");
      expect_at(135, 9, DI, 1, 9'h000, "top_stop9");
      expect_at(139, 9, DI, 0, 9'h000, "top_close9");
      expect_at(140, 9, DI, 0, 9'h000, "top_stay9");
      expect_at(141, 9, DI, 0, 9'h080, "top_latch8");
      expect_at(142, 9, DD, 0, 9'h080, "top_down");
      expect_at(144, 8, DI, 1, 9'h000, "top_stop8");
      expect_at(148, 8, DI, 0, 9'h000, "top_close8");
      for (int f = 2; f <= 9; f++) arr_q.push_back(f);
      arr_q.push_back(8);
      goto_edge(118); car_call = 9'h100;
      goto_edge(119); car_call = '0;
      goto_edge(141); hall_call = 9'h080;
      goto_edge(142); hall_call = '0;

      goto_edge(152);
      vectors++;
      if (arr_q.size() != 0) begin
         miscompares++;
         $display("FAIL arrivals_left: %0d expected arrive pulses never seen, required 0", arr_q.size());
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL checks_left: %0d checkpoints never reached, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
